dma_priority_arbiter: RTL
=========================

// Module: dma_priority_arbiter
// PURPOSE
//  Parametrised successor of the DMA priority-logic slice: arbitrates NUM_CH DMA requests,
//  runs the HRQ/HLDA bus-hold handshake with the CPU and drives one-hot DACK for the
//  granted channel. Adds fixed/rotating priority, per-channel masks, software requests
//  and programmable DREQ/DACK polarity. Sits between channel pins and timing/control.
// PARAMETERS
//  NUM_CH   4   number of DMA channels, legal 2..8; CHW = $clog2(NUM_CH) (localparam)
// PORTS
//  CLK            in   1       system clock, all logic on rising edge
//  RESET          in   1       synchronous, active-high reset
//  DREQ           in   NUM_CH  channel request pins, level sensitive, polarity per DREQ_ACT_LOW
//  SW_REQ         in   NUM_CH  software request bits from request register (not maskable)
//  MASK           in   NUM_CH  1 = channel's hardware DREQ ignored
//  ROT_PRI        in   1       0 = fixed priority (ch0 highest), 1 = rotating priority
//  DREQ_ACT_LOW   in   1       1 = DREQ active-low
//  DACK_ACT_HIGH  in   1       1 = DACK active-high
//  HLDA           in   1       hold acknowledge from CPU
//  SVC_DONE       in   1       one-cycle pulse from timing/control: service of active ch ended (TC/EOP)
//  HRQ            out  1       hold request to CPU
//  DACK           out  NUM_CH  acknowledge, one-hot when granted, polarity per DACK_ACT_HIGH
//  ACT_CH         out  CHW     index of latched/granted channel
//  BUSY           out  1       1 in any state other than IDLE
// BEHAVIOUR
//  - Effective request: req[i] = ((DREQ[i]^DREQ_ACT_LOW) & ~MASK[i]) | SW_REQ[i].
//  - Reset (RESET=1 at edge): state=IDLE, HRQ=0, grant=0, ACT_CH=0, BUSY=0, prio_ptr=0.
//    DACK = grant ? onehot : 0, then XOR'd to {NUM_CH{~DACK_ACT_HIGH}} when inactive (comb.).
//    Reset mid-operation drops HRQ/DACK on the same edge; no pointer update.
//  - Priority: fixed -> lowest index wins. Rotating -> search starts at prio_ptr, wraps
//    modulo NUM_CH; after a completed service of ch k, prio_ptr = (k+1) mod NUM_CH.
//    Switching ROT_PRI 1->0 leaves prio_ptr stored but unused.
//  - FSM (registered outputs, all transitions on CLK edge):
//    IDLE:    any req -> REQ; latch winner in ACT_CH; HRQ=1 after that edge (1-cycle latency).
//    REQ:     HLDA=1 & req[ACT_CH]=1 -> GRANT; DACK[ACT_CH] active after that edge.
//             HLDA=1 & req[ACT_CH]=0 (request withdrawn) -> RELEASE, no DACK ever issued.
//             HLDA=0 -> stay; winner NOT re-arbitrated (late higher-priority req waits).
//    GRANT:   SVC_DONE=1 -> RELEASE; HRQ=0, DACK inactive after edge; rotate prio_ptr.
//             HLDA=0 without SVC_DONE (CPU revoke) -> IDLE; HRQ=0, DACK inactive, no rotate.
//             SVC_DONE & HLDA=0 same cycle -> RELEASE path (completion wins).
//             MASK/DREQ changes of active ch ignored until service ends.
//    RELEASE: HRQ=0; wait HLDA=0 -> IDLE. Next request may raise HRQ one cycle later.
//  - At most one DACK active at any time; DACK only active in GRANT; HRQ=1 only in REQ/GRANT.
//  - SVC_DONE outside GRANT ignored. DACK polarity change applies combinationally.
// TESTING
//  1 Reset: RESET=1 two cycles, DREQ=4'b1111 -> HRQ=0, DACK=4'b1111 (ACT_HIGH=0), BUSY=0.
//  2 Fixed: DREQ=4'b0110, HLDA 2 cycles after HRQ -> ACT_CH=1, DACK=4'b1101; SVC_DONE ->
//    HRQ=0; drop HLDA -> next round ACT_CH=2.
//  3 Rotating: ROT_PRI=1, req ch0..3 all held, 4 rounds -> grant order 0,1,2,3, then 0.
//  4 Mask/SW: MASK=4'b0001, DREQ on ch0 only -> no HRQ; SW_REQ[0]=1 -> HRQ, ACT_CH=0.
//  5 Withdraw/revoke: ch3 drops DREQ before HLDA -> RELEASE, DACK never active; HLDA
//    dropped in GRANT -> DACK inactive next edge, prio_ptr unchanged.
//  6 Polarity/reset mid-grant: DREQ_ACT_LOW=1,DACK_ACT_HIGH=1, DREQ=4'b1011 -> DACK=4'b0100;
//    RESET in GRANT -> HRQ=0, DACK=4'b0000 next edge.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: picks one of NUM_CH requests (fixed or rotating priority),
// runs the HRQ/HLDA bus-hold handshake with the CPU and drives a one-hot DACK.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CHW = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic [NUM_CH-1:0] i_sw_req,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_rot_pri,
    input  logic              i_dreq_act_low,
    input  logic              i_dack_act_high,
    input  logic              i_hlda,
    input  logic              i_svc_done,
    output logic              o_hrq,
    output logic [NUM_CH-1:0] o_dack,
    output logic [CHW-1:0]    o_act_ch,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CHW-1:0]     r_act_ch;
    logic [CHW-1:0]     w_act_ch_nxt;
    logic [CHW-1:0]     r_prio_ptr;
    logic [CHW-1:0]     w_prio_ptr_nxt;
    logic [NUM_CH-1:0]  w_req;
    logic [CHW-1:0]     w_base;
    logic [CHW:0]       w_sum;
    logic [CHW-1:0]     w_winner;
    logic               w_any_req;
    logic [NUM_CH-1:0]  w_onehot;

    assign w_req     = ((i_dreq ^ {NUM_CH{i_dreq_act_low}}) & ~i_mask) | i_sw_req;
    assign w_any_req = |w_req;
    assign w_base    = i_rot_pri ? r_prio_ptr : '0;

    // Walk from the lowest-priority slot up so the highest-priority requester is written last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_winner = '0;
        w_sum    = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            w_sum = {1'b0, w_base} + (CHW + 1)'(off);
            if (w_sum >= (CHW + 1)'(NUM_CH)) begin
                w_sum = w_sum - (CHW + 1)'(NUM_CH);
            end
            if (w_req[w_sum[CHW-1:0]]) begin
                w_winner = w_sum[CHW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_act_ch_nxt   = r_act_ch;
        w_prio_ptr_nxt = r_prio_ptr;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt  = REQ;
                    w_act_ch_nxt = w_winner;
                end
            end
            REQ: begin
                if (i_hlda) begin
                    w_state_nxt = w_req[r_act_ch] ? GRANT : RELEASE;
                end
            end
            GRANT: begin
                if (i_svc_done) begin
                    w_state_nxt = RELEASE;
                    if (i_rot_pri) begin
                        w_prio_ptr_nxt = (r_act_ch == CHW'(NUM_CH - 1)) ? '0 : r_act_ch + 1'b1;
                    end
                end else if (!i_hlda) begin
                    w_state_nxt = IDLE;
                end
            end
            RELEASE: begin
                if (!i_hlda) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (i_reset) begin
            r_state    <= IDLE;
            r_act_ch   <= '0;
            r_prio_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_act_ch   <= w_act_ch_nxt;
            r_prio_ptr <= w_prio_ptr_nxt;
        end
    end

    assign w_onehot = (r_state == GRANT) ? (NUM_CH'(1) << r_act_ch) : '0;
    assign o_dack   = w_onehot ^ {NUM_CH{~i_dack_act_high}};
    assign o_hrq    = (r_state == REQ) || (r_state == GRANT);
    assign o_busy   = (r_state != IDLE);
    assign o_act_ch = r_act_ch;

endmodule
